// File: rtl/pkt_rate_limiter_pkg.sv
// Shared constants and types for the packet rate limiter.
// Holds ctrl framing codes, FSM encoding and token-counter guard width.
package pkt_rate_limiter_pkg;

    localparam logic [7:0] IO_HDR_CTRL  = 8'hFF;
    localparam logic [7:0] PAYLOAD_CTRL = 8'h00;

    // Extra bits carried by next-token arithmetic so that
    // refill/debit cannot wrap before saturation is applied.
    localparam int TOKEN_GUARD = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2
    } rl_state_e;

endpackage

// File: rtl/pkt_rate_limiter_bucket.sv
// Token bucket: refill tick counter plus saturating signed token counter.
// Ports: refill config in, debit pulse in, tokens/gate_open out.
module rl_token_bucket
    import pkt_rate_limiter_pkg::*;
#(
    parameter int TOKEN_WIDTH = 20,
    parameter int TICK_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [TOKEN_WIDTH-2:0]        tokens_per_tick,
    input  logic [TICK_WIDTH-1:0]         tick_period,
    input  logic [TOKEN_WIDTH-2:0]        bucket_max,
    input  logic                          debit,
    output logic signed [TOKEN_WIDTH-1:0] tokens,
    output logic                          gate_open
);

    localparam int NW = TOKEN_WIDTH + TOKEN_GUARD;
    localparam logic signed [NW-1:0] TOK_MIN =
        {{(TOKEN_GUARD + 1){1'b1}}, {(TOKEN_WIDTH - 1){1'b0}}};

    logic [TICK_WIDTH-1:0]         r_tick;
    logic signed [TOKEN_WIDTH-1:0] r_tokens;

    logic [TICK_WIDTH-1:0]         w_last;
    logic                          w_refill;
    logic signed [NW-1:0]          w_cur;
    logic signed [NW-1:0]          w_add;
    logic signed [NW-1:0]          w_sub;
    logic signed [NW-1:0]          w_sum;
    logic signed [NW-1:0]          w_max;
    logic signed [TOKEN_WIDTH-1:0] w_next;

    // Period 0 behaves as 1. Using >= lets a period that is lowered
    // below the running count fire at once instead of wrapping.
    always_comb begin
        w_last   = (tick_period == '0) ? '0 : tick_period - 1'b1;
        w_refill = (r_tick >= w_last);
    end

    always_comb begin
        w_cur = {{TOKEN_GUARD{r_tokens[TOKEN_WIDTH-1]}}, r_tokens};
        w_add = '0;
        if (w_refill) begin
            w_add = {{(TOKEN_GUARD + 1){1'b0}}, tokens_per_tick};
        end
        w_sub = {{(NW - 1){1'b0}}, debit};
        w_sum = w_cur + w_add - w_sub;
        w_max = {{(TOKEN_GUARD + 1){1'b0}}, bucket_max};
        if (w_sum > w_max) begin
            w_next = w_max[TOKEN_WIDTH-1:0];
        end else if (w_sum < TOK_MIN) begin
            w_next = TOK_MIN[TOKEN_WIDTH-1:0];
        end else begin
            w_next = w_sum[TOKEN_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick   <= '0;
            r_tokens <= '0;
        end else begin
            r_tick   <= w_refill ? '0 : r_tick + 1'b1;
            r_tokens <= w_next;
        end
    end

    assign tokens    = r_tokens;
    assign gate_open = (r_tokens > 0);

endmodule

// File: rtl/pkt_rate_limiter.sv
// Packet-boundary rate limiter between FIFO controller and output queues.
// Ports: in_* stream in, out_* registered stream out, rl_* config/stats.
module pkt_rate_limiter
    import pkt_rate_limiter_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int CTRL_WIDTH  = DATA_WIDTH / 8,
    parameter int TOKEN_WIDTH = 20,
    parameter int TICK_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [CTRL_WIDTH-1:0]  in_ctrl,
    input  logic                   in_wr,
    output logic                   in_rdy,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [CTRL_WIDTH-1:0]  out_ctrl,
    output logic                   out_wr,
    input  logic                   out_rdy,
    input  logic                   rl_enable,
    input  logic [TOKEN_WIDTH-2:0] rl_tokens_per_tick,
    input  logic [TICK_WIDTH-1:0]  rl_tick_period,
    input  logic [TOKEN_WIDTH-2:0] rl_bucket_max,
    output logic [TOKEN_WIDTH-1:0] rl_tokens,
    output logic [31:0]            rl_pkt_count,
    output logic [31:0]            rl_stall_count
);

    rl_state_e r_state;
    rl_state_e w_state_nxt;

    logic [DATA_WIDTH-1:0] r_out_data;
    logic [CTRL_WIDTH-1:0] r_out_ctrl;
    logic                  r_out_wr;
    logic [31:0]           r_pkt_count;
    logic [31:0]           r_stall_count;

    logic                          w_is_hdr;
    logic                          w_is_pay;
    logic                          w_accept;
    logic                          w_eop;
    logic                          w_gate_open;
    logic                          w_gate_closed;
    logic                          w_stall;
    logic                          w_debit;
    logic signed [TOKEN_WIDTH-1:0] w_tokens;

    assign w_is_hdr = (in_ctrl == CTRL_WIDTH'(IO_HDR_CTRL));
    assign w_is_pay = (in_ctrl == CTRL_WIDTH'(PAYLOAD_CTRL));

    // Tokens only gate a packet start; mid-packet words always flow.
    assign w_gate_closed = (r_state == ST_IDLE) && rl_enable && !w_gate_open;
    assign w_accept      = in_wr && in_rdy;
    assign w_debit       = w_accept && rl_enable;
    assign w_stall       = in_wr && out_rdy && w_gate_closed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_eop       = 1'b0;
        if (w_accept) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_is_hdr) begin
                        w_state_nxt = ST_HDR;
                    end else if (w_is_pay) begin
                        w_state_nxt = ST_PAYLOAD;
                    end else begin
                        w_eop = 1'b1;
                    end
                end
                ST_HDR: begin
                    if (w_is_pay) begin
                        w_state_nxt = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (!w_is_pay) begin
                        w_state_nxt = ST_IDLE;
                        w_eop       = 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Held low in reset so upstream never pushes into a block being cleared.
    always_comb begin
        in_rdy = !reset && out_rdy && !w_gate_closed;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_wr      <= 1'b0;
            r_out_data    <= '0;
            r_out_ctrl    <= '0;
            r_pkt_count   <= '0;
            r_stall_count <= '0;
        end else begin
            r_out_wr <= w_accept;
            if (w_accept) begin
                r_out_data <= in_data;
                r_out_ctrl <= in_ctrl;
            end
            if (w_eop) begin
                r_pkt_count <= r_pkt_count + 32'd1;
            end
            if (w_stall) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    rl_token_bucket #(
        .TOKEN_WIDTH (TOKEN_WIDTH),
        .TICK_WIDTH  (TICK_WIDTH)
    ) u_bucket (
        .clk             (clk),
        .reset           (reset),
        .tokens_per_tick (rl_tokens_per_tick),
        .tick_period     (rl_tick_period),
        .bucket_max      (rl_bucket_max),
        .debit           (w_debit),
        .tokens          (w_tokens),
        .gate_open       (w_gate_open)
    );

    assign out_wr         = r_out_wr;
    assign out_data       = r_out_data;
    assign out_ctrl       = r_out_ctrl;
    assign rl_tokens      = w_tokens;
    assign rl_pkt_count   = r_pkt_count;
    assign rl_stall_count = r_stall_count;

endmodule

// File: doc/pkt_rate_limiter.md
Name: pkt_rate_limiter

Overview:
- Downstream neighbour of the SRAM-backed FIFO controller.
- Consumes its out_data/out_ctrl/out_wr stream and paces whole packets to the output queues.
- Uses a per-port token bucket with one 64-bit word per token.
- Packets are never split or dropped: gating decisions are made only at packet boundaries.
- Configuration and statistics are exposed as flat ports for the local register block.

Parameters:
- DATA_WIDTH, 64, data bus width in bits.
- CTRL_WIDTH, DATA_WIDTH/8, ctrl bus width.
- TOKEN_WIDTH, 20, width of the signed token counter.
- TICK_WIDTH, 16, width of the refill-period counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  DATA_WIDTH  word from FIFO controller.
- in_ctrl  in  CTRL_WIDTH  ctrl from FIFO controller.
- in_wr  in  1  word valid from FIFO controller.
- in_rdy  out  1  this block can take a word this cycle.
- out_data  out  DATA_WIDTH  registered word to output queues.
- out_ctrl  out  CTRL_WIDTH  registered ctrl.
- out_wr  out  1  registered word valid.
- out_rdy  in  1  downstream ready; almost-full semantics, one word of slack.
- rl_enable  in  1  when 0, the block is a pure one-cycle pipeline stage with no gating.
- rl_tokens_per_tick  in  TOKEN_WIDTH-1  tokens added per refill tick.
- rl_tick_period  in  TICK_WIDTH  cycles between refills; a value of 0 is treated as 1.
- rl_bucket_max  in  TOKEN_WIDTH-1  positive saturation level of the token counter.
- rl_tokens  out  TOKEN_WIDTH  current signed token count, for readback.
- rl_pkt_count  out  32  packets passed (wraps).
- rl_stall_count  out  32  cycles a packet start was held for lack of tokens (wraps).

Behaviour:
- Reset values: out_wr=0, out_data=0, out_ctrl=0, in_rdy=0, tokens=0, tick counter=0, state=IDLE, both counters=0.
- Packet framing:
  - Module-header words have ctrl=0xFF.
  - Payload words have ctrl=0x00.
  - The last word is the first word after payload with ctrl!=0 (byte-valid mask).
- FSM states:
  - IDLE: waiting for first word.
  - HDR: inside module headers.
  - PAYLOAD: inside payload.
- FSM transitions, on each accepted word (in_wr && in_rdy):
  - IDLE -> HDR if ctrl==0xFF; IDLE -> PAYLOAD if ctrl==0.
  - HDR -> PAYLOAD on ctrl==0.
  - PAYLOAD -> IDLE on ctrl!=0.
  - A packet-start word with ctrl!=0xFF and !=0 (single-word packet) increments rl_pkt_count and stays in IDLE.
- in_rdy:
  - in_rdy = out_rdy && !(state==IDLE && rl_enable && tokens<=0).
  - The gate applies only in IDLE; once a packet starts it streams at full rate until EOP.
- Latency: exactly one cycle.
  - out_wr <= in_wr && in_rdy.
  - out_data/out_ctrl load on accept and hold otherwise.
- rl_pkt_count increments on the cycle the EOP word is accepted.
- Token arithmetic, evaluated every cycle:
  - refill = rl_tokens_per_tick when the tick counter reaches period-1 (the counter then clears), else 0.
  - debit = 1 per accepted word when rl_enable, else 0.
  - next = tokens + refill - debit, computed at TOKEN_WIDTH+1 bits.
  - Saturate at +rl_bucket_max and at -2^(TOKEN_WIDTH-1).
  - Simultaneous refill and debit net in the same cycle.
- Deficit: tokens may go negative mid-packet. The next packet waits until tokens>0.
- rl_stall_count increments each cycle with state==IDLE, in_wr pending, out_rdy=1 and the gate closed.
- Configuration changes take effect on the next cycle; in-flight packets are unaffected.
- Lowering rl_bucket_max below the current tokens clamps at the next update.
- rl_enable 1->0 mid-packet: debits stop and the current packet continues. Tokens keep refilling up to max.
- Asynchronous reset mid-packet: state returns to IDLE and the partial packet is discarded from this block's view. The upstream FIFO is reset by the same signal.

Decomposition:
- Shared package holds:
  - IO_HDR_CTRL=8'hFF.
  - PAYLOAD_CTRL=8'h00.
  - FSM state encodings IDLE/HDR/PAYLOAD.
  - Token saturation helper constants.
- One natural sub-module, rl_token_bucket: tick counter, signed token counter, saturation. Its interface is refill config, debit pulse, tokens out, and gate_open=(tokens>0).

Test Plan:
- Pass-through: rl_enable=0, a 1-header + 4-payload + EOP packet with out_rdy=1 -> out stream identical, each word one cycle later; rl_pkt_count=1; tokens unchanged at 0.
- Gate closed: enable=1, tokens=0, period=10, tokens_per_tick=3, one 6-word packet presented at t0.
  - in_rdy low until first refill at cycle 10.
  - Packet then streams back-to-back; tokens end at -3.
  - rl_stall_count=10.
- Deficit recovery: tokens=-3 with the next packet waiting -> blocked through tick 1 (tokens 0); released after tick 2 (tokens 3).
- Saturation: bucket_max=8, tokens_per_tick=5, no traffic for 4 ticks -> tokens reads 8, never 20.
- Backpressure: out_rdy low for 3 cycles mid-payload -> in_rdy low for those cycles; no word lost or duplicated; debit only on accepted words.
- Async reset asserted mid-PAYLOAD between clock edges -> out_wr=0 and tokens=0 immediately. The next packet is treated as a new start from IDLE.
